// File: rtl/regdst_sel_pipe.sv
// regdst_sel_pipe
//
// Picks the destination register address for the instruction entering EX
// from NUM_SRC candidates. It then carries that address and its effective
// write-enable down a DEPTH-stage pipeline, from stage 0 (EX) to stage
// DEPTH-1 (WB). It handles load-use stall bubbles, branch flushes and x0
// write suppression. Each stage also reports whether it will write either
// of two source addresses, for use by the forwarding and hazard units.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset, clears every stage
//   src_addr      NUM_SRC flattened candidates, candidate i at [i*AW +: AW]
//   sel           candidate index; out-of-range selects address 0
//   in_valid      an instruction is presented this cycle
//   reg_write_in  the presented instruction writes the register file
//   stall         load-use stall: hold stage 0, inject a bubble into stage 1
//   flush         branch/jump flush: bubble stages 0 and 1 (beats stall)
//   rs1_addr      source address 1 to compare against every stage
//   rs2_addr      source address 2 to compare against every stage
//   stage_addr    flattened per-stage destination address
//   stage_we      per-stage effective write-enable
//   wb_addr       address of the last stage
//   wb_we         write-enable of the last stage
//   rs1_match     bit k set when stage k will write rs1_addr
//   rs2_match     bit k set when stage k will write rs2_addr

module regdst_sel_pipe #(
  parameter int AW            = 5,
  parameter int NUM_SRC       = 4,
  parameter int SEL_W         = 2,
  parameter int DEPTH         = 3,
  parameter int ZERO_SUPPRESS = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SRC*AW-1:0]  src_addr,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   in_valid,
  input  logic                   reg_write_in,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [AW-1:0]          rs1_addr,
  input  logic [AW-1:0]          rs2_addr,
  output logic [DEPTH*AW-1:0]    stage_addr,
  output logic [DEPTH-1:0]       stage_we,
  output logic [AW-1:0]          wb_addr,
  output logic                   wb_we,
  output logic [DEPTH-1:0]       rs1_match,
  output logic [DEPTH-1:0]       rs2_match
);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DEPTH-1:0] we_q;

  logic [AW-1:0] sel_addr;
  logic          zero_kill;
  logic          new_we;
  logic [AW-1:0] new_addr;

  // Candidate mux. The default covers select values that name no
  // candidate, so those values produce address 0.
  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_addr = src_addr[i*AW +: AW];
      end
    end
  end

  // A non-writing entry always carries address 0. This keeps every bubble
  // identical, whatever its origin.
  always_comb begin
    zero_kill = (ZERO_SUPPRESS != 0) && (sel_addr == '0);
    new_we    = in_valid & reg_write_in & ~zero_kill;
    new_addr  = new_we ? sel_addr : '0;
  end

  // Stages 2 and up always advance. Stages 0 and 1 depend on
  // flush/stall. During a stall, stage 0 keeps its old contents and
  // stage 1 receives a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        addr_q[k] <= '0;
      end
      we_q <= '0;
    end else begin
      for (int k = 2; k < DEPTH; k++) begin
        addr_q[k] <= addr_q[k-1];
        we_q[k]   <= we_q[k-1];
      end
      if (flush) begin
        addr_q[0] <= '0;
        we_q[0]   <= 1'b0;
        addr_q[1] <= '0;
        we_q[1]   <= 1'b0;
      end else if (stall) begin
        addr_q[1] <= '0;
        we_q[1]   <= 1'b0;
      end else begin
        addr_q[0] <= new_addr;
        we_q[0]   <= new_we;
        addr_q[1] <= addr_q[0];
        we_q[1]   <= we_q[0];
      end
    end
  end

  // Flatten the stages and compute the match flags. Address 0 never
  // matches, because x0 is hard-wired and must not be forwarded.
  always_comb begin
    stage_addr = '0;
    rs1_match  = '0;
    rs2_match  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      stage_addr[k*AW +: AW] = addr_q[k];
      rs1_match[k] = we_q[k] && (addr_q[k] == rs1_addr) && (rs1_addr != '0);
      rs2_match[k] = we_q[k] && (addr_q[k] == rs2_addr) && (rs2_addr != '0);
    end
  end

  assign stage_we = we_q;
  assign wb_addr  = addr_q[DEPTH-1];
  assign wb_we    = we_q[DEPTH-1];

endmodule

// File: tb/tb_regdst_sel_pipe.sv
// tb_regdst_sel_pipe
//
// Bench for regdst_sel_pipe with default parameters. It drives two
// instances from the same inputs: one with x0 suppression (dut) and one
// without it (dut_nz). The bench covers a table of single-capture
// vectors, hand-written multi-cycle sequences (reset, stall, flush,
// forwarding, mid-stream reset) and a random flow. In the random flow,
// the expected WB entries go into a queue when stimulus is driven and
// come out when they reach WB.

module tb_regdst_sel_pipe;

  localparam int AW = 5;
  localparam int NUM_SRC = 4;
  localparam int SEL_W = 2;
  localparam int DEPTH = 3;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_SRC*AW-1:0] src_addr;
  logic [SEL_W-1:0]      sel;
  logic                  in_valid;
  logic                  reg_write_in;
  logic                  stall;
  logic                  flush;
  logic [AW-1:0]         rs1_addr;
  logic [AW-1:0]         rs2_addr;

  logic [DEPTH*AW-1:0]   stage_addr,  stage_addr_nz;
  logic [DEPTH-1:0]      stage_we,    stage_we_nz;
  logic [AW-1:0]         wb_addr,     wb_addr_nz;
  logic                  wb_we,       wb_we_nz;
  logic [DEPTH-1:0]      rs1_match,   rs1_match_nz;
  logic [DEPTH-1:0]      rs2_match,   rs2_match_nz;

  int tests;
  int fails;

  regdst_sel_pipe #(
    .AW(AW), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .DEPTH(DEPTH), .ZERO_SUPPRESS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_addr(src_addr), .sel(sel),
    .in_valid(in_valid), .reg_write_in(reg_write_in), .stall(stall), .flush(flush),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .stage_addr(stage_addr), .stage_we(stage_we), .wb_addr(wb_addr), .wb_we(wb_we),
    .rs1_match(rs1_match), .rs2_match(rs2_match)
  );

  regdst_sel_pipe #(
    .AW(AW), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .DEPTH(DEPTH), .ZERO_SUPPRESS(0)
  ) dut_nz (
    .clk(clk), .rst_n(rst_n), .src_addr(src_addr), .sel(sel),
    .in_valid(in_valid), .reg_write_in(reg_write_in), .stall(stall), .flush(flush),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .stage_addr(stage_addr_nz), .stage_we(stage_we_nz), .wb_addr(wb_addr_nz), .wb_we(wb_we_nz),
    .rs1_match(rs1_match_nz), .rs2_match(rs2_match_nz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic [NUM_SRC*AW-1:0] src;
    logic [SEL_W-1:0]  sel;
    logic              v;
    logic              w;
    logic [AW-1:0]     exp_addr;
    logic              exp_we;
    logic [AW-1:0]     exp_addr_nz;
    logic              exp_we_nz;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
  } ent_t;

  vec_t vecs[6];
  ent_t sbq[$];
  ent_t sbq_nz[$];

  function automatic logic [NUM_SRC*AW-1:0] mk(input logic [AW-1:0] c0, input logic [AW-1:0] c1,
                                                input logic [AW-1:0] c2, input logic [AW-1:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  // Advance one edge; sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic [NUM_SRC*AW-1:0] s, input logic [SEL_W-1:0] sl,
                               input logic v, input logic w, input logic st, input logic fl);
    rst_n        = r;
    src_addr     = s;
    sel          = sl;
    in_valid     = v;
    reg_write_in = w;
    stall        = st;
    flush        = fl;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  function automatic logic [AW-1:0] saddr(input int k);
    return stage_addr[k*AW +: AW];
  endfunction

  logic [NUM_SRC*AW-1:0] base;

  initial begin
    tests = 0;
    fails = 0;
    rs1_addr = '0;
    rs2_addr = '0;
    base = mk(5'd13, 5'd5, 5'd7, 5'd9);

    vecs[0] = '{"sel2_write",  base,                         2'd2, 1'b1, 1'b1, 5'd7,  1'b1, 5'd7,  1'b1};
    vecs[1] = '{"sel0_write",  base,                         2'd0, 1'b1, 1'b1, 5'd13, 1'b1, 5'd13, 1'b1};
    vecs[2] = '{"no_regwrite", base,                         2'd3, 1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0};
    vecs[3] = '{"not_valid",   base,                         2'd1, 1'b0, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0};
    vecs[4] = '{"x0_write",    mk(5'd13, 5'd0, 5'd7, 5'd9),  2'd1, 1'b1, 1'b1, 5'd0,  1'b0, 5'd0,  1'b1};
    vecs[5] = '{"sel3_write",  base,                         2'd3, 1'b1, 1'b1, 5'd9,  1'b1, 5'd9,  1'b1};

    // Reset for two edges: everything reads zero.
    applyStimulus(1'b0, base, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset_stage_we",   stage_we,   0);
    checkOutput("reset_stage_addr", stage_addr, 0);
    checkOutput("reset_wb",         {wb_addr, wb_we}, 0);

    // Normal flow: one write to 7, then idle.
    applyStimulus(1'b1, base, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("flow_stage0_addr", saddr(0), 7);
    checkOutput("flow_stage0_we",   stage_we[0], 1);
    applyStimulus(1'b1, base, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("flow_edge2_wb_we", wb_we, 0);
    tick();
    checkOutput("flow_wb_addr", wb_addr, 7);
    checkOutput("flow_wb_we",   wb_we, 1);
    tick();
    checkOutput("flow_edge4_wb_we", wb_we, 0);

    // Table of single-edge captures into stage 0, for both instances.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, vecs[i].src, vecs[i].sel, vecs[i].v, vecs[i].w, 1'b0, 1'b0);
      tick();
      checkOutput({vecs[i].name, "_addr"},    saddr(0),                 vecs[i].exp_addr);
      checkOutput({vecs[i].name, "_we"},      stage_we[0],              vecs[i].exp_we);
      checkOutput({vecs[i].name, "_addr_nz"}, stage_addr_nz[AW-1:0],    vecs[i].exp_addr_nz);
      checkOutput({vecs[i].name, "_we_nz"},   stage_we_nz[0],           vecs[i].exp_we_nz);
    end
    // The last vector left 9 in stage 0; recapture x0 to test matching on 0.
    applyStimulus(1'b1, vecs[4].src, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    rs1_addr = 5'd0;
    tick();
    checkOutput("x0_nz_we_set",    stage_we_nz[0], 1);
    checkOutput("x0_nz_no_match",  rs1_match_nz, 0);

    // Stall: capture 7, stall two cycles with a different instruction presented.
    applyStimulus(1'b1, base, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();
    applyStimulus(1'b1, base, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b1, base, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      checkOutput($sformatf("stall%0d_stage0", c), {saddr(0), stage_we[0]}, {5'd7, 1'b1});
      checkOutput($sformatf("stall%0d_stage1", c), {saddr(1), stage_we[1]}, 0);
    end
    applyStimulus(1'b1, base, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("stall_release_stage1", {saddr(1), stage_we[1]}, {5'd7, 1'b1});
    checkOutput("stall_release_wb_we",  wb_we, 0);
    tick();
    checkOutput("stall_late_wb", {wb_addr, wb_we}, {5'd7, 1'b1});

    // Flush (then flush+stall): A in stage 0, B presented under flush.
    for (int m = 0; m < 2; m++) begin
      applyStimulus(1'b1, base, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); tick(); tick();
      applyStimulus(1'b1, base, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, base, 2'd3, 1'b1, 1'b1, m[0], 1'b1);
      tick();
      checkOutput($sformatf("flush%0d_we", m),   stage_we, 0);
      checkOutput($sformatf("flush%0d_addr", m), stage_addr, 0);
      applyStimulus(1'b1, base, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput($sformatf("flush%0d_wb1", m), {wb_addr, wb_we}, 0);
      tick();
      checkOutput($sformatf("flush%0d_wb2", m), {wb_addr, wb_we}, 0);
    end

    // Forwarding: 9, 13, 9 in flight gives stage0=9, stage1=13, stage2=9.
    applyStimulus(1'b1, base, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, base, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, base, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, base, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    rs1_addr = 5'd9;
    rs2_addr = 5'd5;
    #1;
    checkOutput("fwd_rs1_match", rs1_match, 3'b101);
    checkOutput("fwd_rs2_match", rs2_match, 3'b000);
    rs2_addr = 5'd13;
    #1;
    checkOutput("fwd_rs2_13", rs2_match, 3'b010);
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;

    // Mid-stream reset with three valid entries in flight.
    applyStimulus(1'b1, base, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, base, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, base, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("mid_full_we", stage_we, 3'b111);
    applyStimulus(1'b0, base, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("mid_reset_we",   stage_we, 0);
    checkOutput("mid_reset_addr", stage_addr, 0);
    applyStimulus(1'b1, base, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("post_reset_stage",  {saddr(0), stage_we}, {5'd5, 3'b001});
    applyStimulus(1'b1, base, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("post_reset_wb", {wb_addr, wb_we}, {5'd5, 1'b1});

    // Random uninterrupted flow through the scoreboard, then drain with idles.
    sbq.delete();
    sbq_nz.delete();
    for (int n = 0; n < 60; n++) begin
      logic [AW-1:0] c [NUM_SRC];
      logic [SEL_W-1:0] s;
      logic v, w, we1, we0;
      ent_t e1, e0;
      for (int j = 0; j < NUM_SRC; j++) begin
        c[j] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      end
      s = SEL_W'($urandom_range(0, 3));
      v = (n < 50) ? 1'($urandom_range(0, 1)) : 1'b0;
      w = 1'($urandom_range(0, 1));
      we0 = v & w;
      we1 = we0 & (c[s] != 5'd0);
      e1.we = we1;  e1.addr = we1 ? c[s] : 5'd0;
      e0.we = we0;  e0.addr = we0 ? c[s] : 5'd0;
      sbq.push_back(e1);
      sbq_nz.push_back(e0);
      applyStimulus(1'b1, mk(c[0], c[1], c[2], c[3]), s, v, w, 1'b0, 1'b0);
      tick();
      if (sbq.size() >= DEPTH) begin
        e1 = sbq.pop_front();
        e0 = sbq_nz.pop_front();
        checkOutput($sformatf("sb_wb_%0d", n),    {wb_addr, wb_we},       e1);
        checkOutput($sformatf("sb_wb_nz_%0d", n), {wb_addr_nz, wb_we_nz}, e0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
